ad9958_spi_responder: RTL
=========================

Name: ad9958_spi_responder

Overview:
- Behavioural/synthesizable model of the AD9958 serial port and register file: the receiving end of the DDS SPI link.
- Decodes cs/sclk/sdio frames (1-bit or 4-bit mode), writes buffered channel registers, and transfers them to active outputs on io_update.
- Used as the loopback target in the controller bench and on-FPGA self-test. Active FTW/ASF outputs are compared against the values the controller was commanded to send.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on cs, sclk, sdio, io_update and master_reset.

Ports:
- clock  in  1  system clock; must be at least 4x the sclk frequency.
- reset_n  in  1  asynchronous active-low reset.
- cs  in  1  chip select, active low.
- sclk  in  1  serial clock; data is sampled on its rising edge.
- sdio  in  4  serial data; sdio[0] only in 1-bit mode; nibble with sdio[3] as the MSB in 4-bit mode.
- master_reset  in  1  active high; restores register defaults.
- io_update  in  1  rising edge transfers buffered registers to active outputs.
- csr  out  8  channel select register (active).
- ftw_ch0, ftw_ch1  out  32  active CFTW0 per channel.
- pow_ch0, pow_ch1  out  14  active CPOW0[13:0] per channel.
- asf_ch0, asf_ch1  out  10  active ACR[9:0] per channel.
- reg_wr_strobe  out  1  one-cycle pulse when a complete register has been written to the buffer.
- reg_wr_addr  out  5  address of the last completed write.
- update_pulse  out  1  one-cycle pulse on each accepted io_update edge.
- frame_error  out  1  one-cycle pulse when a frame is aborted mid-register or carries a read instruction.

Behaviour:
- Reset (reset_n low, async):
  - all synchronizers cleared; cs synchronizer cleared to 1.
  - csr = 8'hF0; every ftw/pow/asf and every buffer = 0.
  - all strobes = 0; FSM in IDLE.
- master_reset (synchronized, level high): same values as reset_n. The FSM is forced to IDLE and any in-progress frame is discarded with no frame_error. Has priority over io_update and sclk activity.
- Edge detection: sclk and io_update rising edges are detected on the synchronized signals. An sclk edge is ignored while cs is high.
- Mode: 4-bit when csr[2:1] == 2'b11, otherwise 1-bit. Each shift adds 1 or 4 bits, MSB first. A byte completes after 8 or 2 sclk edges.
- FSM states:
  - IDLE -> INSTR on the cs falling edge; byte counter and bit counter cleared.
  - INSTR: collect 1 byte. bit7 = R/W (1 = read), bits[4:0] = address.
    - A read instruction pulses frame_error and goes to DRAIN.
    - A write goes to DATA with the expected length from the address: 0x00 = 1 byte; 0x01, 0x03, 0x06 = 3 bytes; 0x02, 0x05, 0x07 = 2 bytes; 0x04 and 0x08-0x18 = 4 bytes; 0x19-0x1F = 0 bytes (return to INSTR, no strobe).
  - DATA: shift bytes into a 32-bit shift register. On the final byte:
    - write the buffer and pulse reg_wr_strobe with reg_wr_addr in the same cycle;
    - return to INSTR, so multiple instructions per cs frame are supported.
  - DRAIN: ignore sclk until cs rises.
  - Any state -> IDLE on the cs rising edge. If the rise lands in INSTR with a partial byte, or in DATA, pulse frame_error and discard the partial data; no buffer is written.
- Register targets:
  - CSR (0x00) is written directly to active csr when its byte completes. A mode change applies from the next byte.
  - Channel registers (0x03-0x06) write the ch0 buffer if csr[6] and the ch1 buffer if csr[7]; both if both bits are set; neither if neither is set (strobe still pulses).
  - 0x01, 0x02 and 0x07-0x18 are length-decoded and otherwise discarded.
- io_update rising edge: copy all buffers to active outputs in one cycle and pulse update_pulse.
  - An io_update coinciding with a buffer write copies the pre-write buffer value; the new value is visible at the next update.
- Latency: reg_wr_strobe occurs SYNC_STAGES+1 cycles after the final sclk rising edge. Active outputs change SYNC_STAGES+1 cycles after the io_update rising edge.

Decomposition:
- Shared package ad9958_pkg:
  - register address constants (CSR = 0x00, FR1 = 0x01, CFR = 0x03, CFTW0 = 0x04, CPOW0 = 0x05, ACR = 0x06);
  - register-length function;
  - CSR bit positions (CH0_EN = 6, CH1_EN = 7, MODE = 2:1) and CSR_DEFAULT = 8'hF0.
- Sub-module ad9958_spi_deserializer: synchronizers, edge detect, 1/4-bit shifting and byte assembly; outputs byte_valid, byte_data, frame_start, frame_end. The top level holds the FSM and the register file.

Test Plan:
- 1-bit mode: write 0x04 with 0x1234_5678 (csr = F0), then io_update -> ftw_ch0 = ftw_ch1 = 32'h1234_5678; reg_wr_addr = 4, one strobe.
- Write CSR = 0x46 (ch0 only, 4-bit), then 4-bit write 0x06 with 0x00_03FF, then io_update -> asf_ch0 = 10'h3FF, asf_ch1 = 0; the data phase uses 6 sclk edges.
- One cs frame carrying 0x04 + 4 bytes followed by 0x05 + 2 bytes (0x3FFF) -> two strobes; after update, pow = 14'h3FFF and ftw updated.
- cs rises after 2 of 4 CFTW0 data bytes -> frame_error pulse, buffer unchanged, update leaves ftw at its prior value.
- Read instruction 0x84 followed by 32 clocks -> frame_error; no strobe; outputs unchanged.
- master_reset during a data phase, then after an earlier update -> csr = F0, all ftw/asf = 0, no frame_error; the next frame decodes normally.

Source files
------------

// File: rtl/ad9958_pkg.sv
// AD9958 register map, CSR fields, channel register bundle
// and the instruction-address to data-length decode.
package ad9958_pkg;

  localparam logic [4:0] CSR_ADDR   = 5'h00;
  localparam logic [4:0] FR1_ADDR   = 5'h01;
  localparam logic [4:0] CFR_ADDR   = 5'h03;
  localparam logic [4:0] CFTW0_ADDR = 5'h04;
  localparam logic [4:0] CPOW0_ADDR = 5'h05;
  localparam logic [4:0] ACR_ADDR   = 5'h06;

  localparam int CH0_EN  = 6;
  localparam int CH1_EN  = 7;
  localparam int MODE_HI = 2;
  localparam int MODE_LO = 1;

  localparam logic [7:0] CSR_DEFAULT = 8'hF0;

  typedef struct packed {
    logic [31:0] ftw;
    logic [13:0] pow;
    logic [9:0]  asf;
  } chan_regs_t;

  // Data bytes that follow a write instruction.
  function automatic logic [2:0] reg_len(input logic [4:0] a);
    logic [2:0] n;
    unique case (a)
      CSR_ADDR:                     n = 3'd1;
      FR1_ADDR, CFR_ADDR, ACR_ADDR: n = 3'd3;
      5'h02, CPOW0_ADDR, 5'h07:     n = 3'd2;
      default:
        n = (a > 5'h18) ? 3'd0 : 3'd4;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ad9958_spi_deserializer.sv
// Synchronizes cs/sclk/sdio/io_update/master_reset, detects edges
// and assembles 1-bit or 4-bit serial data into bytes (MSB first).
// Ports: clock, reset_n; raw cs, sclk, sdio[3:0], master_reset,
// io_update; mode4 selects nibble shifting. Outputs byte_valid and
// byte_data (combinational on the completing sclk edge), frame_start,
// frame_end, bit_pending, update_rise and synchronized mreset.
module ad9958_spi_deserializer
  import ad9958_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       cs,
  input  logic       sclk,
  input  logic [3:0] sdio,
  input  logic       master_reset,
  input  logic       io_update,
  input  logic       mode4,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_start,
  output logic       frame_end,
  output logic       bit_pending,
  output logic       update_rise,
  output logic       mreset
);

  // {master_reset, io_update, sdio, sclk, cs}; cs idles high
  localparam logic [7:0] SYNC_RST = 8'h01;

  logic [7:0] sq [SYNC_STAGES];
  logic       cs_s;
  logic       sclk_s;
  logic       upd_s;
  logic [3:0] sdio_s;
  logic       cs_d;
  logic       sclk_d;
  logic       upd_d;
  logic [6:0] sh;
  logic [2:0] cnt;
  logic       sclk_rise;
  logic       last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sq[i] <= SYNC_RST;
    end else begin
      sq[0] <= {master_reset, io_update, sdio, sclk, cs};
      for (int i = 1; i < SYNC_STAGES; i++)
        sq[i] <= sq[i-1];
    end
  end

  assign {mreset, upd_s, sdio_s, sclk_s, cs_s} =
    sq[SYNC_STAGES-1];

  assign frame_start = cs_d & ~cs_s;
  assign frame_end   = ~cs_d & cs_s;
  assign sclk_rise   = sclk_s & ~sclk_d & ~cs_s;
  assign update_rise = upd_s & ~upd_d;

  assign last = mode4 ? (cnt == 3'd1) : (cnt == 3'd7);
  assign byte_data = mode4 ? {sh[3:0], sdio_s}
                           : {sh[6:0], sdio_s[0]};
  assign byte_valid  = sclk_rise & last & ~mreset;
  assign bit_pending = cnt != 3'd0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_d   <= 1'b1;
      sclk_d <= 1'b0;
      upd_d  <= 1'b0;
      sh     <= '0;
      cnt    <= '0;
    end else begin
      cs_d   <= cs_s;
      sclk_d <= sclk_s;
      upd_d  <= upd_s;
      if (mreset || frame_start || frame_end) begin
        cnt <= '0;
      end else if (sclk_rise) begin
        sh  <= byte_data[6:0];
        cnt <= last ? 3'd0 : cnt + 3'd1;
      end
    end
  end

endmodule

// File: rtl/ad9958_spi_responder.sv
// AD9958 serial-port responder: instruction/data FSM, buffered
// channel registers and io_update transfer to active outputs.
// Ports: clock, reset_n, cs, sclk, sdio[3:0], master_reset,
// io_update in; csr, ftw/pow/asf per channel, reg_wr_strobe,
// reg_wr_addr, update_pulse, frame_error out (all registered).
module ad9958_spi_responder
  import ad9958_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        sclk,
  input  logic [3:0]  sdio,
  input  logic        master_reset,
  input  logic        io_update,
  output logic [7:0]  csr,
  output logic [31:0] ftw_ch0,
  output logic [31:0] ftw_ch1,
  output logic [13:0] pow_ch0,
  output logic [13:0] pow_ch1,
  output logic [9:0]  asf_ch0,
  output logic [9:0]  asf_ch1,
  output logic        reg_wr_strobe,
  output logic [4:0]  reg_wr_addr,
  output logic        update_pulse,
  output logic        frame_error
);

  typedef enum logic [1:0] {
    IDLE,
    INSTR,
    DATA,
    DRAIN
  } state_t;

  state_t      state;
  logic [4:0]  addr;
  logic [2:0]  left;
  logic [23:0] acc;
  chan_regs_t  buf0;
  chan_regs_t  buf1;
  chan_regs_t  act0;
  chan_regs_t  act1;

  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        frame_start;
  logic        frame_end;
  logic        bit_pending;
  logic        update_rise;
  logic        mreset;
  logic        mode4;
  logic [31:0] word;
  logic [2:0]  ilen;

  assign mode4 = csr[MODE_HI:MODE_LO] == 2'b11;
  assign word  = {acc, byte_data};
  assign ilen  = reg_len(byte_data[4:0]);

  ad9958_spi_deserializer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_deser (
    .clock       (clock),
    .reset_n     (reset_n),
    .cs          (cs),
    .sclk        (sclk),
    .sdio        (sdio),
    .master_reset(master_reset),
    .io_update   (io_update),
    .mode4       (mode4),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .frame_start (frame_start),
    .frame_end   (frame_end),
    .bit_pending (bit_pending),
    .update_rise (update_rise),
    .mreset      (mreset)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      addr          <= '0;
      left          <= '0;
      acc           <= '0;
      csr           <= CSR_DEFAULT;
      buf0          <= '0;
      buf1          <= '0;
      act0          <= '0;
      act1          <= '0;
      reg_wr_strobe <= 1'b0;
      reg_wr_addr   <= '0;
      update_pulse  <= 1'b0;
      frame_error   <= 1'b0;
    end else begin
      reg_wr_strobe <= 1'b0;
      update_pulse  <= 1'b0;
      frame_error   <= 1'b0;
      if (mreset) begin
        state       <= IDLE;
        addr        <= '0;
        left        <= '0;
        acc         <= '0;
        csr         <= CSR_DEFAULT;
        buf0        <= '0;
        buf1        <= '0;
        act0        <= '0;
        act1        <= '0;
        reg_wr_addr <= '0;
      end else begin
        // Copies pre-write buffers if a write lands this cycle.
        if (update_rise) begin
          act0         <= buf0;
          act1         <= buf1;
          update_pulse <= 1'b1;
        end
        if (frame_end) begin
          frame_error <= (state == DATA) ||
                         (state == INSTR && bit_pending);
          state <= IDLE;
        end else if (frame_start) begin
          state <= INSTR;
        end else if (byte_valid) begin
          unique case (state)
            INSTR: begin
              if (byte_data[7]) begin
                frame_error <= 1'b1;
                state       <= DRAIN;
              end else if (ilen != 3'd0) begin
                state <= DATA;
                addr  <= byte_data[4:0];
                left  <= ilen;
                acc   <= '0;
              end
            end
            DATA: begin
              acc  <= word[23:0];
              left <= left - 3'd1;
              if (left == 3'd1) begin
                state         <= INSTR;
                reg_wr_strobe <= 1'b1;
                reg_wr_addr   <= addr;
                unique case (1'b1)
                  addr == CSR_ADDR:
                    csr <= word[7:0];
                  addr == CFTW0_ADDR: begin
                    if (csr[CH0_EN]) buf0.ftw <= word;
                    if (csr[CH1_EN]) buf1.ftw <= word;
                  end
                  addr == CPOW0_ADDR: begin
                    if (csr[CH0_EN]) buf0.pow <= word[13:0];
                    if (csr[CH1_EN]) buf1.pow <= word[13:0];
                  end
                  addr == ACR_ADDR: begin
                    if (csr[CH0_EN]) buf0.asf <= word[9:0];
                    if (csr[CH1_EN]) buf1.asf <= word[9:0];
                  end
                  default: ;
                endcase
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign ftw_ch0 = act0.ftw;
  assign ftw_ch1 = act1.ftw;
  assign pow_ch0 = act0.pow;
  assign pow_ch1 = act1.pow;
  assign asf_ch0 = act0.asf;
  assign asf_ch1 = act1.asf;

endmodule
